// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: start/busy/done handshake and operand/result bus between the
// issuing logic (master) and the multi-cycle multiply/divide sequencer (slave).
//   start        request, sampled only while the sequencer is idle
//   op           0 = multiply, 1 = divide
//   a, b         multiplicand/dividend and multiplier/divisor
//   busy         high while iterations are running
//   done         one-cycle pulse, result valid from this cycle on
//   result       product, or {remainder, quotient}
//   div_by_zero  set together with done for a divide by zero
interface muldiv_seq_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic               op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned multiply/divide sequencer sharing a single
// WIDTH-bit add/subtract unit (b XOR sub, carry-in = sub).
//   Multiply: shift-add over {c, hi, lo}, result = {hi, lo}.
//   Divide:   restoring division over {r, q}, result = {r, q}.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears all state
//   bus    muldiv_seq_if slave modport (start/op/a/b in, busy/done/result/
//          div_by_zero out)
// Latency: start accepted at edge t -> busy in cycles t+1..t+WIDTH, done in
// cycle t+WIDTH+1. A divide by zero skips RUN and reports done in cycle t+1.
module muldiv_seq #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_q, op_d;
  // acc holds hi (multiply) or r (divide); low holds lo or q;
  // opnd holds m (multiply) or d (divide).
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     low_q, low_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 dz_q, dz_d;

  // Shared adder
  logic [WIDTH-1:0]     t_low;
  logic [WIDTH-1:0]     add_x;
  logic                 add_sub;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_co;

  // One iteration's outcome
  logic [WIDTH-1:0]     hi_n;
  logic                 c_n;
  logic                 take;
  logic [WIDTH-1:0]     acc_iter;
  logic [WIDTH-1:0]     low_iter;

  // Divide shifts {r, q} left by one before the trial subtraction; only the
  // low WIDTH bits go through the adder, the dropped top bit is r[WIDTH-1].
  assign t_low   = {acc_q[WIDTH-2:0], low_q[WIDTH-1]};
  assign add_x   = op_q ? t_low : acc_q;
  assign add_sub = op_q;

  always_comb begin
    {add_co, add_sum} = {1'b0, add_x}
                      + {1'b0, opnd_q ^ {WIDTH{add_sub}}}
                      + {{WIDTH{1'b0}}, add_sub};
  end

  always_comb begin
    hi_n     = acc_q;
    c_n      = 1'b0;
    take     = 1'b0;
    acc_iter = acc_q;
    low_iter = low_q;
    if (!op_q) begin
      if (low_q[0]) begin
        hi_n = add_sum;
        c_n  = add_co;
      end
      // Right shift of {c, hi, lo}; c always lands in hi's MSB, so it never
      // needs to be stored.
      acc_iter = {c_n, hi_n[WIDTH-1:1]};
      low_iter = {hi_n[0], low_q[WIDTH-1:1]};
    end else begin
      // A set shifted-out bit means t >= 2^WIDTH > d, so the subtraction
      // fits even without a carry-out from the WIDTH-bit adder.
      take     = acc_q[WIDTH-1] | add_co;
      acc_iter = take ? add_sum : t_low;
      low_iter = {low_q[WIDTH-2:0], take};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    low_d    = low_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d   = bus.op;
          cnt_d  = '0;
          acc_d  = '0;
          low_d  = bus.op ? bus.a : bus.b;
          opnd_d = bus.op ? bus.b : bus.a;
          if (bus.op && (bus.b == '0)) begin
            result_d = {bus.a, {WIDTH{1'b1}}};
            dz_d     = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = acc_iter;
        low_d = low_iter;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          result_d = {acc_iter, low_iter};
          dz_d     = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      acc_q    <= '0;
      low_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.result      = result_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed scenarios plus an exhaustive operand sweep for
// muldiv_seq with WIDTH=4.
module tb_muldiv_seq;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  muldiv_seq_if #(.WIDTH(4)) bus();

  muldiv_seq #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launches one operation from IDLE (called #1 after an edge) and follows it
  // to its done cycle; returns one edge later so the sequencer is idle again.
  task automatic do_op(input logic op_i, input logic [3:0] a_i,
                       input logic [3:0] b_i, output int lat,
                       output int busy_cnt, output bit got);
    lat = 0; busy_cnt = 0; got = 1'b0;
    bus.op = op_i; bus.a = a_i; bus.b = b_i; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        got = 1'b1;
        lat = k;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (got) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h expected 00", bus.result); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", bus.div_by_zero); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multiply;
    int lat, bc; bit got;
    do_op(1'b0, 4'd15, 4'd15, lat, bc, got);
    checks++; if (!got) begin errors++; $display("FAIL mul_timeout: no done within 20 cycles"); end
    checks++; if (lat != 5) begin errors++; $display("FAIL mul_latency: got %0d expected 5", lat); end
    checks++; if (bc != 4) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 4", bc); end
    checks++; if (bus.result !== 8'hE1) begin errors++; $display("FAIL mul_15x15: got %h expected e1", bus.result); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL mul_dz: got %b expected 0", bus.div_by_zero); end
  endtask

  task automatic test_divide;
    int lat, bc; bit got;
    do_op(1'b1, 4'd13, 4'd4, lat, bc, got);
    checks++; if (lat != 5) begin errors++; $display("FAIL div_latency: got %0d expected 5", lat); end
    checks++; if (bus.result !== 8'h13) begin errors++; $display("FAIL div_13_4: got %h expected 13", bus.result); end
    do_op(1'b1, 4'd3, 4'd9, lat, bc, got);
    checks++; if (bus.result !== 8'h30) begin errors++; $display("FAIL div_3_9: got %h expected 30", bus.result); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL div_dz: got %b expected 0", bus.div_by_zero); end
  endtask

  task automatic test_div_by_zero;
    int lat, bc; bit got;
    do_op(1'b1, 4'd7, 4'd0, lat, bc, got);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", lat); end
    checks++; if (bc != 0) begin errors++; $display("FAIL dz_busy_cycles: got %0d expected 0", bc); end
    checks++; if (bus.result !== 8'h7F) begin errors++; $display("FAIL dz_result: got %h expected 7f", bus.result); end
    checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", bus.div_by_zero); end
    do_op(1'b0, 4'd0, 4'd9, lat, bc, got);
    checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL after_dz_result: got %h expected 00", bus.result); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL after_dz_flag: got %b expected 0", bus.div_by_zero); end
  endtask

  task automatic test_start_ignored;
    int dones;
    dones = 0;
    bus.op = 1'b0; bus.a = 4'd6; bus.b = 4'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.a = 4'd1; bus.b = 4'd1;   // start stays high through RUN and DONE
    for (int k = 1; k <= 5; k++) begin
      if (bus.done) dones++;
      if (k == 5) begin
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ign_done_at_5: got %b expected 1", bus.done); end
        checks++; if (bus.result !== 8'h2A) begin errors++; $display("FAIL ign_result: got %h expected 2a", bus.result); end
      end else begin
        @(posedge clk); #1;
      end
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL ign_done_count: got %0d expected 1", dones); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ign_idle: got done=%b busy=%b expected 0 0", bus.done, bus.busy); end
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL held_start_accept: got busy=%b expected 1", bus.busy); end
    bus.start = 1'b0;
    for (int k = 0; k < 10 && !bus.done; k++) begin
      @(posedge clk); #1;
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL held_start_done: got %b expected 1", bus.done); end
    checks++; if (bus.result !== 8'h01) begin errors++; $display("FAIL held_start_result: got %h expected 01", bus.result); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    int lat, bc, seen; bit got;
    seen = 0;
    bus.op = 1'b0; bus.a = 4'd9; bus.b = 4'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 0", bus.done); end
    checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL rst_mid_result: got %h expected 00", bus.result); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done || bus.busy) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", seen); end
    do_op(1'b0, 4'd2, 4'd3, lat, bc, got);
    checks++; if (bus.result !== 8'h06) begin errors++; $display("FAIL rst_mid_fresh: got %h expected 06", bus.result); end
    checks++; if (lat != 5) begin errors++; $display("FAIL rst_mid_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_sweep;
    int lat, bc, exp_res; bit got; logic exp_dz;
    for (int o = 0; o < 2; o++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          if (o == 0) begin
            exp_res = ai * bi; exp_dz = 1'b0;
          end else if (bi == 0) begin
            exp_res = ai * 16 + 15; exp_dz = 1'b1;
          end else begin
            exp_res = (ai % bi) * 16 + (ai / bi); exp_dz = 1'b0;
          end
          do_op(o[0], ai[3:0], bi[3:0], lat, bc, got);
          checks++;
          if (!got || bus.result !== 8'(exp_res)) begin
            errors++;
            $display("FAIL sweep op=%0d a=%0d b=%0d: got %h expected %h (done=%0b)", o, ai, bi, bus.result, 8'(exp_res), got);
          end
          checks++;
          if (bus.div_by_zero !== exp_dz) begin
            errors++;
            $display("FAIL sweep_dz op=%0d a=%0d b=%0d: got %b expected %b", o, ai, bi, bus.div_by_zero, exp_dz);
          end
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    test_reset();
    test_multiply();
    test_divide();
    test_div_by_zero();
    test_start_ignored();
    test_reset_mid_run();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
